cnn_input_sequencer: RTL and testbench
======================================

// Module: cnn_input_sequencer
// PURPOSE
//  Front-end feeder for the CNN+DNN top. Takes one host word stream and buffers a full set of DNN weight rows.
//  Replays those rows gap-free, one row per cycle, onto the top's in_weights bus.
//  Then forwards ImageWidth^2 image pixels to in_data/in_valid under the top's out_ready backpressure.
//  Finally waits for the top's out_done. Sits directly upstream of top; replaces hand-driven bench stimulus.
// PARAMETERS
//  BitSize        4   pixel width
//  ImageWidth     8   image side length; pixels per image = ImageWidth^2 = 64
//  MaxNumNerves   4   weight row entries (in_weights row length)
//  M_W_BitSize    4   DNN weight width
//  NumWeightRows  8   rows per weight set (ImageSize + LNN[1] = 4 + 4)
// PORTS
//  clk       in   1                          clock, rising edge
//  res       in   1                          asynchronous reset, active-high
//  start     in   1                          1-cycle request, sampled in IDLE only
//  reuse_w   in   1                          with start: skip LOAD_W, replay stored weights
//  s_valid   in   1                          host word valid
//  s_ready   out  1                          host word ready
//  s_data    in   MaxNumNerves*M_W_BitSize   host word: weight row, or pixel in [BitSize-1:0]
//  w_data    out  [MaxNumNerves][M_W_BitSize] drives top.in_weights
//  w_valid   out  1                          high while w_data carries a replayed row
//  px_valid  out  1                          drives top.in_valid
//  px_data   out  BitSize                    drives top.in_data
//  px_ready  in   1                          from top.out_ready
//  net_done  in   1                          from top.out_done
//  busy      out  1                          state != IDLE
//  done      out  1                          1-cycle pulse, image fully processed
// BEHAVIOUR
//  Reset (async, res=1): state=IDLE; all outputs 0; counters 0; w_loaded=0; buffer contents undefined.
//  Reset mid-operation aborts immediately. reuse_w is treated as 0 until a full LOAD_W has completed again.
//  Handshakes: a transfer happens on a rising edge where valid&&ready.
//   px_valid/px_data hold stable until px_ready. No combinational path from px_ready to px_valid.
//  Weight-row bit order: host word bits [k*M_W_BitSize +: M_W_BitSize] map to w_data[k].
//  Only the low BitSize bits of s_data are used in pixel phase.
//  States and transitions:
//   IDLE:
//    start && !(reuse_w && w_loaded) -> LOAD_W; start && reuse_w && w_loaded -> EMIT_W.
//    start outside IDLE is ignored.
//   LOAD_W:
//    s_ready=1. Each accepted word is written to buf[wcnt] and wcnt++.
//    On the NumWeightRows-th accept: set w_loaded, go to EMIT_W.
//    s_ready is 0 in the following cycle.
//   EMIT_W:
//    Exactly NumWeightRows consecutive cycles, w_valid=1, w_data=buf[0..NumWeightRows-1] in order.
//    No gaps, and px_ready is ignored here. The top has no weight handshake, so contiguity is mandatory.
//    Next state STREAM_PX. After the last row, w_data=0 and w_valid=0.
//   STREAM_PX:
//    One-entry output register. s_ready = (pcnt_in < ImageWidth^2) && (!px_valid || px_ready).
//    Host word accepted: px_data <= s_data[BitSize-1:0], px_valid <= 1.
//    Downstream transfer with no refill: px_valid <= 0.
//    Simultaneous downstream transfer and host accept: refill in the same edge, no bubble.
//    After the ImageWidth^2-th downstream transfer: px_valid=0, go to WAIT_DONE.
//    Surplus host words are not accepted.
//   WAIT_DONE:
//    s_ready=0. On net_done=1: done=1 for one cycle, go to IDLE.
//    A net_done seen in any other state is ignored.
//  Counters: wcnt/rcnt use $clog2(NumWeightRows+1) bits; pcnt_in/pcnt_out use $clog2(ImageWidth^2+1) bits.
//   No wrap-around: counters saturate at their terminal value and clear on IDLE entry.
//  Latency:
//   First w_valid: the cycle after the last LOAD_W accept, or 2 cycles after start with reuse.
//   Pixels: host accept -> px_valid on the next cycle.
// TESTING
//  1. Load: start, then 8 rows {1,0,0,0},{0,1,0,0},{0,0,0,0}x2,{1,0,1,0},{0,1,0,1},...
//     -> w_valid high exactly 8 consecutive cycles; rows in order; no idle cycle between them.
//  2. Pixel stream: px_ready=1 constantly, 64 pixels (0x7,0x2,0x2,0xF,...)
//     -> 64 px transfers in order, one per cycle; px_valid drops after the 64th; s_ready=0 after the 64th accept.
//  3. Backpressure: px_ready toggled 1,0,0,1... -> px_data held stable while stalled; no loss or duplication.
//     Downstream sees exactly 64 pixels.
//  4. Completion: net_done pulsed 5 cycles after the last pixel -> done=1 for one cycle, then IDLE, busy=0.
//     net_done asserted during LOAD_W -> ignored.
//  5. Reuse: a second start with reuse_w=1 -> no host words taken; identical 8-row replay 2 cycles after start.
//     res pulsed mid-STREAM_PX, then start with reuse_w=1 -> goes to LOAD_W (w_loaded was cleared).
//  6. Reset mid-EMIT_W (res high for 1 cycle) -> all outputs 0 asynchronously; state IDLE; start is re-accepted.

Source files
------------

// File: rtl/cnn_input_sequencer.sv
// cnn_input_sequencer: loads one set of DNN weight rows from the host stream,
// replays them gap-free onto the top's weight bus, forwards one image of
// pixels under downstream backpressure, then waits for the network to finish.
//
// state     | meaning
// IDLE      | waiting for start; counters held at zero
// LOAD_W    | accepting NumWeightRows host words into the row buffer
// EMIT_W    | replaying buffered rows, one per cycle, no gaps
// STREAM_PX | forwarding ImageWidth^2 pixels through a one-entry output register
// WAIT_DONE | waiting for net_done, then pulsing done
module cnn_input_sequencer #(
  parameter int BitSize       = 4,
  parameter int ImageWidth    = 8,
  parameter int MaxNumNerves  = 4,
  parameter int M_W_BitSize   = 4,
  parameter int NumWeightRows = 8
) (
  input  logic                                     clk,
  input  logic                                     res,
  input  logic                                     start,
  input  logic                                     reuse_w,
  input  logic                                     s_valid,
  output logic                                     s_ready,
  input  logic [MaxNumNerves*M_W_BitSize-1:0]      s_data,
  output logic [MaxNumNerves-1:0][M_W_BitSize-1:0] w_data,
  output logic                                     w_valid,
  output logic                                     px_valid,
  output logic [BitSize-1:0]                       px_data,
  input  logic                                     px_ready,
  input  logic                                     net_done,
  output logic                                     busy,
  output logic                                     done
);

  localparam int DW   = MaxNumNerves * M_W_BitSize;
  localparam int NPX  = ImageWidth * ImageWidth;
  localparam int WCW  = $clog2(NumWeightRows + 1);
  localparam int PCW  = $clog2(NPX + 1);
  localparam int IDXW = (NumWeightRows > 1) ? $clog2(NumWeightRows) : 1;

  localparam logic [WCW-1:0] NROWS = WCW'(NumWeightRows);
  localparam logic [WCW-1:0] WONE  = WCW'(1);
  localparam logic [PCW-1:0] NPIX  = PCW'(NPX);
  localparam logic [PCW-1:0] PONE  = PCW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_W    = 3'd1,
    EMIT_W    = 3'd2,
    STREAM_PX = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WCW-1:0]     wcnt_q, wcnt_d;
  logic [WCW-1:0]     rcnt_q, rcnt_d;
  logic [PCW-1:0]     pcnt_in_q, pcnt_in_d;
  logic [PCW-1:0]     pcnt_out_q, pcnt_out_d;
  logic               w_loaded_q, w_loaded_d;
  logic               w_valid_q, w_valid_d;
  logic [DW-1:0]      w_data_q, w_data_d;
  logic               px_valid_q, px_valid_d;
  logic [BitSize-1:0] px_data_q, px_data_d;
  logic               done_q, done_d;

  logic [DW-1:0]      wbuf_q [NumWeightRows];
  logic               wr_en;
  logic               host_acc;
  logic               px_xfer;

  // Host ready: always open while loading, gated by pixel budget and output slot while streaming.
  always_comb begin
    s_ready = 1'b0;
    if (state_q == LOAD_W) begin
      s_ready = 1'b1;
    end else if (state_q == STREAM_PX) begin
      s_ready = (pcnt_in_q < NPIX) && (!px_valid_q || px_ready);
    end
  end

  assign host_acc = s_valid && s_ready;
  assign px_xfer  = px_valid_q && px_ready;

  // Next-state and datapath updates for every state.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    pcnt_in_d  = pcnt_in_q;
    pcnt_out_d = pcnt_out_q;
    w_loaded_d = w_loaded_q;
    w_valid_d  = 1'b0;
    w_data_d   = '0;
    px_valid_d = px_valid_q;
    px_data_d  = px_data_q;
    done_d     = 1'b0;
    wr_en      = 1'b0;

    case (state_q)
      IDLE: begin
        wcnt_d     = '0;
        rcnt_d     = '0;
        pcnt_in_d  = '0;
        pcnt_out_d = '0;
        px_valid_d = 1'b0;
        if (start) begin
          state_d = (reuse_w && w_loaded_q) ? EMIT_W : LOAD_W;
        end
      end
      LOAD_W: begin
        if (host_acc) begin
          wr_en  = 1'b1;
          wcnt_d = wcnt_q + WONE;
          if (wcnt_q == NROWS - WONE) begin
            // Row 0 goes out on the very next cycle; with a single-row set it is
            // the word being written right now, so take it straight from the bus.
            w_loaded_d = 1'b1;
            state_d    = EMIT_W;
            w_valid_d  = 1'b1;
            w_data_d   = (wcnt_q == '0) ? s_data : wbuf_q[0];
            rcnt_d     = WONE;
          end
        end
      end
      EMIT_W: begin
        if (rcnt_q < NROWS) begin
          w_valid_d = 1'b1;
          w_data_d  = wbuf_q[rcnt_q[IDXW-1:0]];
          rcnt_d    = rcnt_q + WONE;
        end else begin
          state_d = STREAM_PX;
        end
      end
      STREAM_PX: begin
        if (host_acc) begin
          px_valid_d = 1'b1;
          px_data_d  = s_data[BitSize-1:0];
          pcnt_in_d  = pcnt_in_q + PONE;
        end else if (px_xfer) begin
          px_valid_d = 1'b0;
        end
        if (px_xfer) begin
          pcnt_out_d = pcnt_out_q + PONE;
          if (pcnt_out_q == NPIX - PONE) begin
            px_valid_d = 1'b0;
            state_d    = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (net_done) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset aborts any operation and forgets the weights.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      pcnt_in_q  <= '0;
      pcnt_out_q <= '0;
      w_loaded_q <= 1'b0;
      w_valid_q  <= 1'b0;
      w_data_q   <= '0;
      px_valid_q <= 1'b0;
      px_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      pcnt_in_q  <= pcnt_in_d;
      pcnt_out_q <= pcnt_out_d;
      w_loaded_q <= w_loaded_d;
      w_valid_q  <= w_valid_d;
      w_data_q   <= w_data_d;
      px_valid_q <= px_valid_d;
      px_data_q  <= px_data_d;
      done_q     <= done_d;
    end
  end

  // Weight row buffer; contents are only meaningful once w_loaded is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      wbuf_q[wcnt_q[IDXW-1:0]] <= s_data;
    end
  end

  assign w_data   = w_data_q;
  assign w_valid  = w_valid_q;
  assign px_valid = px_valid_q;
  assign px_data  = px_data_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_cnn_input_sequencer.sv
// Testbench for cnn_input_sequencer: directed weight/pixel vectors, expected
// rows and pixels queued at issue time, popped by negedge monitors.
module tb_cnn_input_sequencer;

  logic            clk;
  logic            res;
  logic            start;
  logic            reuse_w;
  logic            s_valid;
  logic            s_ready;
  logic [15:0]     s_data;
  logic [3:0][3:0] w_data;
  logic            w_valid;
  logic            px_valid;
  logic [3:0]      px_data;
  logic            px_ready;
  logic            net_done;
  logic            busy;
  logic            done;

  cnn_input_sequencer dut (
    .clk      (clk),
    .res      (res),
    .start    (start),
    .reuse_w  (reuse_w),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .w_data   (w_data),
    .w_valid  (w_valid),
    .px_valid (px_valid),
    .px_data  (px_data),
    .px_ready (px_ready),
    .net_done (net_done),
    .busy     (busy),
    .done     (done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] wq[$];
  logic [3:0]  pq[$];

  int px_seen   = 0;
  int first_cyc = 0;
  int last_cyc  = 0;
  int w_run     = 0;
  int done_cnt  = 0;
  logic       hold_pend = 1'b0;
  logic [3:0] hold_data = 4'h0;

  // rows {1,0,0,0},{0,1,0,0},{0,0,0,0}x2,{1,0,1,0},{0,1,0,1},{1,2,3,4},{F,0,0,8}; element k at bits [4k+:4]
  logic [15:0] rows_a [8] = '{16'h0001, 16'h0010, 16'h0000, 16'h0000,
                              16'h0101, 16'h1010, 16'h4321, 16'h800F};
  logic [15:0] rows_b [8] = '{16'h1234, 16'hFEDC, 16'h0F0F, 16'hA5A5,
                              16'h5A5A, 16'h8001, 16'h7777, 16'h0246};
  logic [3:0]  px_head [4] = '{4'h7, 4'h2, 4'h2, 4'hF};
  logic [3:0]  bp_pat = 4'b1001;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] pix_a(input int i);
    logic [3:0] p;
    if (i < 4) p = px_head[i];
    else       p = 4'((i * 7 + 3) % 16);
    return p;
  endfunction

  function automatic logic [3:0] pix_b(input int i);
    return 4'((i * 3 + 1) % 16);
  endfunction

  // Weight scoreboard: every replayed row is popped and compared; each run must be 8 long.
  always @(negedge clk) begin
    if (res) begin
      w_run = 0;
    end else if (w_valid) begin
      if (wq.size() == 0) begin
        chk("w_unexpected_row", 32'(w_data), 32'hFFFF_FFFF);
      end else begin
        chk("w_row", 32'(w_data), 32'(wq.pop_front()));
      end
      w_run++;
    end else if (w_run != 0) begin
      chk("w_run_length", w_run, 8);
      w_run = 0;
    end
  end

  // Pixel scoreboard plus stall-hold check.
  always @(negedge clk) begin
    if (res) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("px_hold_valid", px_valid, 1);
        chk("px_hold_data", px_data, hold_data);
      end
      hold_pend = px_valid && !px_ready;
      hold_data = px_data;
      if (px_valid && px_ready) begin
        if (pq.size() == 0) begin
          chk("px_unexpected", {28'h0, px_data}, 32'hFFFF_FFFF);
        end else begin
          chk("px_data", px_data, pq.pop_front());
        end
        if (px_seen == 0) first_cyc = cyc;
        last_cyc = cyc;
        px_seen++;
      end
    end
    if (done) done_cnt++;
  end

  task automatic host_send(input logic [15:0] d);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (s_ready) break;
      n++;
    end
    chk("host_send_timeout", (n < 200), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic ru);
    tick();
    start   = 1'b1;
    reuse_w = ru;
    tick();
    start   = 1'b0;
    reuse_w = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {w_valid, px_valid, busy, done, s_ready}, 0);
    chk({nm, "_data"}, {16'(w_data), 4'(px_data)}, 0);
  endtask

  initial begin
    int lat;
    int sr_cnt;
    int n;
    res = 1'b1; start = 1'b0; reuse_w = 1'b0; s_valid = 1'b0;
    s_data = 16'h0; px_ready = 1'b1; net_done = 1'b0;
    #3;
    chk_all_zero("reset_state");
    repeat (2) @(posedge clk);
    #1 res = 1'b0;

    // Load 8 rows; net_done during LOAD_W must be ignored.
    for (int i = 0; i < 8; i++) wq.push_back(rows_a[i]);
    pulse_start(1'b0);
    chk("load_s_ready", {busy, s_ready}, 2'b11);
    net_done = 1'b1;
    tick();
    net_done = 1'b0;
    chk("net_done_ignored", {busy, s_ready, done}, 3'b110);
    for (int i = 0; i < 8; i++) host_send(rows_a[i]);
    s_valid = 1'b0;
    chk("w_first_after_load", w_valid, 1);
    chk("load_closed", s_ready, 0);

    // Full-rate pixel stream, then surplus words refused.
    px_seen = 0;
    for (int i = 0; i < 64; i++) pq.push_back(pix_a(i));
    for (int i = 0; i < 64; i++) host_send({12'hA5C, pix_a(i)} ^ 16'(i << 8));
    chk("px_s_ready_full", s_ready, 0);
    s_data = 16'hDEAD;
    tick();
    chk("px_drain", {px_valid, busy}, 2'b01);
    chk("px_count_full_rate", px_seen, 64);
    chk("px_one_per_cycle", last_cyc - first_cyc, 63);
    sr_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      sr_cnt += int'(s_ready);
    end
    s_valid = 1'b0;
    chk("surplus_refused", sr_cnt, 0);
    tick();
    net_done = 1'b1;
    tick();
    net_done = 1'b0;
    chk("done_pulse", {done, busy}, 2'b10);
    tick();
    chk("done_cleared", {done, busy}, 2'b00);
    chk("rows_all_seen", wq.size(), 0);

    // Reuse: no host words, replay starts 2 cycles after start.
    for (int i = 0; i < 8; i++) wq.push_back(rows_a[i]);
    pulse_start(1'b1);
    chk("reuse_prime_s_ready", {s_ready, w_valid}, 0);
    lat = 1;
    while (!w_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("reuse_latency", lat, 2);
    sr_cnt = 0;
    repeat (8) begin
      sr_cnt += int'(s_ready);
      tick();
    end
    chk("reuse_no_host_words", sr_cnt, 0);
    chk("w_off_after_replay", {w_valid, 16'(w_data)}, 0);

    // Backpressure pattern 1,0,0,1 on px_ready.
    px_seen = 0;
    for (int i = 0; i < 64; i++) pq.push_back(pix_b(i));
    fork
      begin
        for (int i = 0; i < 64; i++) host_send({12'h5A3, pix_b(i)});
        s_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 1000 && px_seen < 64; k++) begin
          @(posedge clk);
          #1 px_ready = bp_pat[k % 4];
        end
        px_ready = 1'b1;
      end
    join
    chk("px_count_backpressure", px_seen, 64);
    chk("px_queue_empty", pq.size(), 0);
    repeat (5) tick();
    net_done = 1'b1;
    tick();
    net_done = 1'b0;
    chk("done_pulse_2", {done, busy}, 2'b10);

    // Reset mid-STREAM_PX clears w_loaded: reuse start must go back to LOAD_W.
    for (int i = 0; i < 8; i++) wq.push_back(rows_a[i]);
    pulse_start(1'b1);
    for (int i = 0; i < 10; i++) pq.push_back(pix_a(i + 20));
    for (int i = 0; i < 10; i++) host_send({12'h000, pix_a(i + 20)});
    s_valid = 1'b0;
    n = 0;
    while (pq.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("px_partial_drained", pq.size(), 0);
    chk("stream_busy", busy, 1);
    tick();
    res = 1'b1;
    #1;
    chk_all_zero("reset_stream");
    tick();
    res = 1'b0;
    pulse_start(1'b1);
    chk("reuse_after_reset_loads", {busy, s_ready}, 2'b11);

    // Reset mid-EMIT_W is asynchronous; start accepted afterwards.
    for (int i = 0; i < 8; i++) wq.push_back(rows_b[i]);
    for (int i = 0; i < 8; i++) host_send(rows_b[i]);
    s_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 res = 1'b1;
    #1;
    chk_all_zero("reset_emit_async");
    tick();
    res = 1'b0;
    wq.delete();
    pulse_start(1'b1);
    chk("start_after_emit_reset", {busy, s_ready, w_valid}, 3'b110);

    chk("done_pulse_count", done_cnt, 2);
    res = 1'b1;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
